imem_ctrl: RTL and testbench
============================

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL take parameter BUF_DEPTH, default 2, meaning response-buffer entries (legal values 2 and 4).
REQ-002 SHALL take parameter XLEN, default core_pkg::XLEN (32), meaning address/data width.
REQ-003 SHALL have these ports; the single clock is clk, and reset is reset_n, asynchronous, active-low.
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- f_req  in  1  fetch read request for a 2-instruction pair.
- f_addr0 / f_addr1  in  XLEN each  pair addresses.
- f_ready  out  1  request accepted this cycle.
- f_flush  in  1  redirect; kills in-flight and buffered data.
- f_stall  in  1  fetch cannot consume.
- f_rvalid  out  1  response pair at buffer head.
- f_rdata  out  2xXLEN  instruction pair.
- f_pc  out  2xXLEN  PCs matching f_rdata.
- ld_req  in  1  loader/debug write request.
- ld_addr / ld_wdata  in  XLEN each  write address and data.
- ld_ack  out  1  write performed this cycle.
- mem_ren / mem_wen  out  1 each  memory read / write strobes.
- mem_addr0 / mem_addr1  out  XLEN each  memory addresses.
- mem_wdata  out  XLEN  write data.
- mem_rdata0 / mem_rdata1  in  XLEN each  read data, fixed 1-cycle latency.

Function
REQ-004 SHALL arbitrate one memory port between fetch reads and loader writes, at most one operation per cycle, mem_ren and mem_wen never both 1.
REQ-005 SHALL grant by round-robin on a last_grant bit when both request; a lone requester always wins if otherwise eligible.
REQ-006 SHALL make fetch eligible only when !f_flush and (count + inflight_v - pop) < BUF_DEPTH, where pop = f_rvalid & !f_stall.
REQ-007 SHALL drive f_ready, mem_ren, mem_addr0 = f_addr0 and mem_addr1 = f_addr1 combinationally in the fetch-grant cycle N.
REQ-008 SHALL drive ld_ack, mem_wen, mem_addr0 = ld_addr and mem_wdata = ld_wdata in the loader-grant cycle; loader is eligible even during f_flush.
REQ-009 SHALL, on a read grant, register inflight_v = 1 together with both addresses.
REQ-010 SHALL sample mem_rdata0/1 in cycle N+1 and, if inflight_v & !f_flush, push {pc pair, data pair} into the buffer at the N+1 edge; f_rvalid is therefore first seen at N+2.
REQ-011 SHALL present f_rvalid, f_pc and f_rdata from the buffer head (registered, no bypass) and pop on f_rvalid & !f_stall.
REQ-012 SHALL handle simultaneous push and pop with count unchanged and order preserved (FIFO), including when full.
REQ-013 SHALL, when f_flush = 1, clear inflight_v and empty the buffer at the next edge; f_rvalid SHALL be 0 in the cycle after the flush, and the dropped mem_rdata SHALL never surface.
REQ-014 SHALL never overflow: the credit rule in REQ-006 guarantees a slot for every in-flight read.
REQ-015 SHALL give f_flush priority over f_stall; f_stall alone freezes the head values.
REQ-016 SHALL sustain one read per cycle when !f_stall (1-pair/cycle throughput).
REQ-017 SHALL have memory outputs at zero when no grant.

Reset
REQ-018 SHALL, on reset_n = 0 (asynchronously, including mid-operation), set count = 0, inflight_v = 0 and last_grant = loader (fetch wins first tie); f_ready, f_rvalid, ld_ack, mem_ren and mem_wen = 0; f_pc, f_rdata, mem_addr* and mem_wdata = 0.
REQ-019 SHALL lose any in-flight read on reset, with no response after deassertion.

Structure
REQ-020 SHALL place IMEM_BUF_DEPTH and typedef fetch_pkt_t {pc[FETCH_WIDTH], instr[FETCH_WIDTH]} in core_pkg.
REQ-021 SHALL implement the buffer as sub-module fetch_resp_fifo (parameterised depth, push/pop/flush, count output).

Verification
REQ-022 Reset, then f_req = 1 at addresses 0x0/0x4 with no stall -> f_ready = 1 in cycle N, f_rvalid at N+2 with f_pc = {0x0, 0x4} and data matching memory.
REQ-023 Continuous f_req for 4 cycles at pc 0x0, 0x8, 0x10, 0x18 with no stall -> f_rvalid on 4 consecutive cycles, in order.
REQ-024 f_stall held for 4 cycles during streaming -> f_ready drops once count + inflight = 2, no pair is lost or duplicated, and the head stays frozen.
REQ-025 f_flush in cycle N+1 of the read to 0x20 -> 0x20 pair never output, buffer empty, next request at 0x100 returns first.
REQ-026 ld_req and f_req both held -> grants alternate fetch/loader/fetch; a ld_req write of 0xDEADBEEF to 0x40 is followed by a read of 0x40 returning 0xDEADBEEF.
REQ-027 reset_n asserted with inflight_v = 1 and buffer full -> all outputs 0 immediately and no f_rvalid after release until a new request.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// core_pkg: shared widths, grant encoding and fetch packet type for the instruction memory controller.
package core_pkg;
    localparam int XLEN = 32;
    localparam int FETCH_WIDTH = 2;
    localparam int IMEM_BUF_DEPTH = 2;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_LOAD  = 1'b1
    } grant_t;

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
        logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: fetch, loader and memory-port signals of the instruction memory controller.
interface imem_ctrl_if #(
    parameter int XLEN = core_pkg::XLEN
);
    logic f_req;
    logic [XLEN-1:0] f_addr0;
    logic [XLEN-1:0] f_addr1;
    logic f_ready;
    logic f_flush;
    logic f_stall;
    logic f_rvalid;
    logic [core_pkg::FETCH_WIDTH-1:0][XLEN-1:0] f_rdata;
    logic [core_pkg::FETCH_WIDTH-1:0][XLEN-1:0] f_pc;
    logic ld_req;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_wdata;
    logic ld_ack;
    logic mem_ren;
    logic mem_wen;
    logic [XLEN-1:0] mem_addr0;
    logic [XLEN-1:0] mem_addr1;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata0;
    logic [XLEN-1:0] mem_rdata1;

    modport slave (
        input  f_req, f_addr0, f_addr1, f_flush, f_stall,
        input  ld_req, ld_addr, ld_wdata, mem_rdata0, mem_rdata1,
        output f_ready, f_rvalid, f_rdata, f_pc, ld_ack,
        output mem_ren, mem_wen, mem_addr0, mem_addr1, mem_wdata
    );

    modport master (
        output f_req, f_addr0, f_addr1, f_flush, f_stall,
        output ld_req, ld_addr, ld_wdata, mem_rdata0, mem_rdata1,
        input  f_ready, f_rvalid, f_rdata, f_pc, ld_ack,
        input  mem_ren, mem_wen, mem_addr0, mem_addr1, mem_wdata
    );
endinterface

// File: rtl/imem_ctrl_fetch_resp_fifo.sv
// fetch_resp_fifo: registered-head response FIFO with flush; depth must be a power of two.
module fetch_resp_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = IMEM_BUF_DEPTH,
    parameter type T = fetch_pkt_t,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  T din,
    input  logic pop,
    input  logic flush,
    output T dout,
    output logic valid,
    output logic [CW-1:0] count
);
    T mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign dout = mem[rd_ptr];
    assign valid = count != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: arbitrates one memory port between paired instruction fetch reads and loader writes,
// buffering read responses in a credit-managed FIFO.
module imem_ctrl
    import core_pkg::*;
#(
    parameter int BUF_DEPTH = IMEM_BUF_DEPTH,
    parameter int XLEN = core_pkg::XLEN
) (
    input logic clk,
    input logic reset_n,
    imem_ctrl_if.slave bus
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [FETCH_WIDTH-1:0][XLEN-1:0] pc;
        logic [FETCH_WIDTH-1:0][XLEN-1:0] instr;
    } pkt_t;

    pkt_t push_pkt;
    pkt_t head;
    grant_t last_grant;
    logic inflight_v;
    logic fetch_gnt;
    logic load_gnt;
    logic head_v;
    logic pop;
    logic push;
    logic [XLEN-1:0] pc0_q;
    logic [XLEN-1:0] pc1_q;
    logic [CW-1:0] count;
    logic [CW:0] credit;

    assign pop = head_v & !bus.f_stall;
    assign push = inflight_v & !bus.f_flush;
    // Slots already spoken for once this cycle's pop retires; a new read needs one left over.
    assign credit = (CW + 1)'(count) + (CW + 1)'(inflight_v) - (CW + 1)'(pop);
    assign push_pkt = '{pc: {pc1_q, pc0_q}, instr: {bus.mem_rdata1, bus.mem_rdata0}};

    always_comb begin
        fetch_gnt = reset_n & bus.f_req & !bus.f_flush & (credit < (CW + 1)'(BUF_DEPTH))
                  & (!bus.ld_req | last_grant == GNT_LOAD);
        load_gnt = reset_n & bus.ld_req & !fetch_gnt;
        bus.f_ready = fetch_gnt;
        bus.ld_ack = load_gnt;
        bus.mem_ren = fetch_gnt;
        bus.mem_wen = load_gnt;
        bus.mem_addr0 = fetch_gnt ? bus.f_addr0 : load_gnt ? bus.ld_addr : '0;
        bus.mem_addr1 = fetch_gnt ? bus.f_addr1 : '0;
        bus.mem_wdata = load_gnt ? bus.ld_wdata : '0;
        bus.f_rvalid = head_v;
        bus.f_pc = head_v ? head.pc : '0;
        bus.f_rdata = head_v ? head.instr : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_v <= 1'b0;
            pc0_q <= '0;
            pc1_q <= '0;
            last_grant <= GNT_LOAD;
        end else begin
            inflight_v <= fetch_gnt;
            if (fetch_gnt) begin
                pc0_q <= bus.f_addr0;
                pc1_q <= bus.f_addr1;
            end
            last_grant <= fetch_gnt ? GNT_FETCH : load_gnt ? GNT_LOAD : last_grant;
        end
    end

    fetch_resp_fifo #(
        .DEPTH(BUF_DEPTH),
        .T(pkt_t)
    ) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(push),
        .din(push_pkt),
        .pop(pop),
        .flush(bus.f_flush),
        .dout(head),
        .valid(head_v),
        .count(count)
    );
endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed and random stimulus for imem_ctrl against a queue-based reference model.
module tb_imem_ctrl;
    localparam int DEPTH = 2;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] d;
    } pair_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    imem_ctrl_if #(.XLEN(32)) bus ();
    imem_ctrl #(.BUF_DEPTH(DEPTH), .XLEN(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    logic [31:0] wmap [logic [31:0]];
    pair_t q [$];
    pair_t pend;
    bit pend_v;
    bit last_ld;
    int vectors;
    int miscompares;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return wmap.exists(a) ? wmap[a] : (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Memory with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_ren) begin
            bus.mem_rdata0 <= rd(bus.mem_addr0);
            bus.mem_rdata1 <= rd(bus.mem_addr1);
        end
        if (bus.mem_wen) wmap[bus.mem_addr0] = bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ready"}, 64'(bus.f_ready), 64'h0);
        check({tag, "_rvalid"}, 64'(bus.f_rvalid), 64'h0);
        check({tag, "_ack"}, 64'(bus.ld_ack), 64'h0);
        check({tag, "_ren"}, 64'(bus.mem_ren), 64'h0);
        check({tag, "_wen"}, 64'(bus.mem_wen), 64'h0);
        check({tag, "_addr0"}, 64'(bus.mem_addr0), 64'h0);
        check({tag, "_addr1"}, 64'(bus.mem_addr1), 64'h0);
        check({tag, "_wdata"}, 64'(bus.mem_wdata), 64'h0);
        check({tag, "_pc"}, bus.f_pc, 64'h0);
        check({tag, "_rdata"}, bus.f_rdata, 64'h0);
    endtask

    task automatic set_f(input logic req, input logic [31:0] a);
        bus.f_req = req;
        bus.f_addr0 = a;
        bus.f_addr1 = a + 32'd4;
    endtask

    task automatic model_reset();
        q.delete();
        pend_v = 1'b0;
        last_ld = 1'b1;
    endtask

    // One clock: check outputs against the model, then advance the model across the edge.
    task automatic tick();
        bit mpop, fg, lg, fl;
        int credit;
        pair_t np;
        #1;
        mpop = q.size() != 0 && !bus.f_stall;
        credit = q.size() + int'(pend_v) - int'(mpop);
        fl = bus.f_flush;
        fg = bus.f_req && !fl && credit < DEPTH && (!bus.ld_req || last_ld);
        lg = bus.ld_req && !fg;
        np.pc = {bus.f_addr1, bus.f_addr0};
        np.d = {rd(bus.f_addr1), rd(bus.f_addr0)};
        check("f_ready", 64'(bus.f_ready), 64'(fg));
        check("ld_ack", 64'(bus.ld_ack), 64'(lg));
        check("mem_ren", 64'(bus.mem_ren), 64'(fg));
        check("mem_wen", 64'(bus.mem_wen), 64'(lg));
        check("mem_addr0", 64'(bus.mem_addr0), 64'(fg ? bus.f_addr0 : lg ? bus.ld_addr : 32'h0));
        check("mem_addr1", 64'(bus.mem_addr1), 64'(fg ? bus.f_addr1 : 32'h0));
        check("mem_wdata", 64'(bus.mem_wdata), 64'(lg ? bus.ld_wdata : 32'h0));
        check("f_rvalid", 64'(bus.f_rvalid), 64'(q.size() != 0));
        check("f_pc", bus.f_pc, q.size() != 0 ? q[0].pc : 64'h0);
        check("f_rdata", bus.f_rdata, q.size() != 0 ? q[0].d : 64'h0);
        @(posedge clk);
        if (fl) begin
            q.delete();
            pend_v = 1'b0;
        end else begin
            if (mpop) void'(q.pop_front());
            if (pend_v) q.push_back(pend);
            pend_v = fg;
            pend = np;
        end
        if (fg) last_ld = 1'b0;
        else if (lg) last_ld = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        vectors = 0;
        miscompares = 0;
        model_reset();
        set_f(1'b1, 32'h0);
        bus.f_stall = 1'b0;
        bus.f_flush = 1'b0;
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'h10;
        bus.ld_wdata = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        set_f(1'b0, 32'h0);
        bus.ld_req = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        // Single pair at 0x0/0x4, response two cycles after the grant.
        set_f(1'b1, 32'h0);
        tick();
        set_f(1'b0, 32'h0);
        tick();
        #1 check("pair0_pc", bus.f_pc, 64'h0000_0004_0000_0000);
        check("pair0_data", bus.f_rdata, {rd(32'h4), rd(32'h0)});
        repeat (2) tick();

        // Back-to-back stream.
        for (int i = 0; i < 4; i++) begin
            set_f(1'b1, 32'(i * 8));
            tick();
        end
        set_f(1'b0, 32'h0);
        repeat (4) tick();

        // Stall in the middle of a stream.
        for (int i = 0; i < 10; i++) begin
            set_f(1'b1, 32'h200 + 32'(i * 8));
            bus.f_stall = i >= 2 && i < 6;
            tick();
        end
        set_f(1'b0, 32'h0);
        bus.f_stall = 1'b0;
        repeat (4) tick();

        // Flush the cycle after the 0x20 read is granted.
        set_f(1'b1, 32'h20);
        tick();
        set_f(1'b0, 32'h0);
        bus.f_flush = 1'b1;
        tick();
        bus.f_flush = 1'b0;
        set_f(1'b1, 32'h100);
        tick();
        set_f(1'b0, 32'h0);
        tick();
        #1 check("after_flush_pc", bus.f_pc, 64'h0000_0104_0000_0100);
        repeat (3) tick();

        // Contended fetch/loader, then read back the written word.
        set_f(1'b1, 32'h40);
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'h40;
        bus.ld_wdata = 32'hDEAD_BEEF;
        repeat (4) tick();
        bus.ld_req = 1'b0;
        set_f(1'b0, 32'h0);
        repeat (4) tick();
        set_f(1'b1, 32'h40);
        tick();
        set_f(1'b0, 32'h0);
        tick();
        #1 check("raw_data", 64'(bus.f_rdata[0]), 64'hDEAD_BEEF);
        repeat (3) tick();

        // Asynchronous reset with a read in flight and the buffer occupied.
        bus.f_stall = 1'b1;
        set_f(1'b1, 32'h300);
        tick();
        set_f(1'b1, 32'h308);
        tick();
        #3 reset_n = 1'b0;
        #1 chk_zero("midreset");
        set_f(1'b0, 32'h0);
        bus.f_stall = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            a = 32'($urandom_range(0, 63)) << 3;
            set_f($urandom_range(0, 9) < 6, a);
            bus.f_stall = $urandom_range(0, 9) < 3;
            bus.f_flush = $urandom_range(0, 19) == 0;
            bus.ld_req = $urandom_range(0, 9) < 2;
            bus.ld_addr = 32'($urandom_range(0, 63)) << 2;
            bus.ld_wdata = $urandom;
            tick();
        end
        set_f(1'b0, 32'h0);
        bus.f_stall = 1'b0;
        bus.f_flush = 1'b0;
        bus.ld_req = 1'b0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
